// File: rtl/lif_array.sv
// ============================================================================
// Module   : lif_array
// Brief    : N independent leaky integrate-and-fire neurons with refractory
//            period and a saturating global spike counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_array #(
    parameter int N          = 4,
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACT    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N*WIDTH-1:0]   current,
    input  logic [WIDTH-1:0]     threshold,
    input  logic                 cnt_clr,
    output logic [N-1:0]         spike,
    output logic [N*WIDTH-1:0]   state,
    output logic [15:0]          spike_total
);

    localparam int             C_RW      = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
    localparam logic [C_RW-1:0] C_REFRACT = C_RW'(REFRACT);
    localparam logic [C_RW-1:0] C_ONE     = C_RW'(1);

    logic [N-1:0] w_fire;
    logic [16:0]  w_pop;
    logic [16:0]  w_tot_sum;
    logic [15:0]  w_tot_sat;
    logic [15:0]  r_total;

    generate
        for (genvar g = 0; g < N; g++) begin : g_neuron
            logic [WIDTH-1:0] r_state;
            logic [C_RW-1:0]  r_ref;
            logic             r_spike;
            logic [WIDTH-1:0] w_cur;
            logic [WIDTH-1:0] w_leak;
            logic [WIDTH:0]   w_sum;
            logic [WIDTH-1:0] w_sat;

            assign w_cur  = current[g*WIDTH +: WIDTH];
            assign w_leak = r_state >> LEAK_SHIFT;
            // leak never exceeds state, so the subtraction cannot wrap
            assign w_sum  = {1'b0, r_state} - {1'b0, w_leak} + {1'b0, w_cur};
            assign w_sat  = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
            assign w_fire[g] = ena && (r_ref == '0) && (w_sat >= threshold);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= '0;
                    r_ref   <= '0;
                    r_spike <= 1'b0;
                end else begin
                    r_spike <= w_fire[g];
                    if (ena) begin
                        if (r_ref != '0) begin
                            r_state <= '0;
                            r_ref   <= r_ref - C_ONE;
                        end else if (w_fire[g]) begin
                            r_state <= '0;
                            r_ref   <= C_REFRACT;
                        end else begin
                            r_state <= w_sat;
                        end
                    end
                end
            end

            assign state[g*WIDTH +: WIDTH] = r_state;
            assign spike[g]                = r_spike;
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + {16'd0, w_fire[i]};
        end
    end

    assign w_tot_sum = {1'b0, r_total} + w_pop;
    assign w_tot_sat = w_tot_sum[16] ? 16'hFFFF : w_tot_sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
        end else if (cnt_clr) begin
            r_total <= '0;
        end else if (ena) begin
            r_total <= w_tot_sat;
        end
    end

    assign spike_total = r_total;

endmodule

`default_nettype wire

// File: tb/tb_lif_array.sv
// ============================================================================
// Module   : tb_lif_array
// Brief    : Directed self-checking bench for lif_array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lif_array;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [31:0] current;
    logic [7:0]  threshold;
    logic        cnt_clr;
    logic [3:0]  spike;
    logic [31:0] state;
    logic [15:0] spike_total;
    logic [3:0]  spike_r0;
    logic [31:0] state_r0;
    logic [15:0] spike_total_r0;

    int n_total;
    int n_bad;

    lif_array dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .current(current),
        .threshold(threshold), .cnt_clr(cnt_clr),
        .spike(spike), .state(state), .spike_total(spike_total)
    );

    // Second instance without refractory period, used for counter saturation
    lif_array #(.REFRACT(0)) dut_r0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .current(current),
        .threshold(threshold), .cnt_clr(cnt_clr),
        .spike(spike_r0), .state(state_r0), .spike_total(spike_total_r0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ena       = 1'b0;
        cnt_clr   = 1'b0;
        current   = '0;
        threshold = '0;
        rst_n     = 1'b0;
        #2;
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        ena       = 1'b1;
        current   = {4{8'd200}};
        threshold = 8'd0;
        tick();
        tick();
        n_total++;
        if (state !== 32'd0 || spike !== 4'd0 || spike_total !== 16'd0) begin
            n_bad++;
            $display("FAIL reset: state=%h spike=%b total=%0d, want 0/0/0", state, spike, spike_total);
        end
        n_total++;
        if (state_r0 !== 32'd0 || spike_r0 !== 4'd0 || spike_total_r0 !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_r0: state=%h spike=%b total=%0d, want 0/0/0", state_r0, spike_r0, spike_total_r0);
        end
        do_reset();
    endtask

    task automatic test_integrate();
        int e [8] = '{40, 60, 70, 75, 78, 79, 80, 80};
        do_reset();
        current   = {24'd0, 8'd40};
        threshold = 8'd100;
        ena       = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_total++;
            if (state[7:0] !== 8'(e[i]) || spike !== 4'd0 || state[31:8] !== 24'd0) begin
                n_bad++;
                $display("FAIL integrate[%0d]: state=%h spike=%b, want state0=%0d spike=0", i, state, spike, e[i]);
            end
        end
    endtask

    task automatic test_fire_period();
        logic [3:0]  esp;
        logic [15:0] etot;
        do_reset();
        current   = {24'd0, 8'd200};
        threshold = 8'd150;
        ena       = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            esp  = (k % 3 == 1) ? 4'b0001 : 4'b0000;
            etot = 16'((k + 2) / 3);
            n_total++;
            if (spike !== esp || state[7:0] !== 8'd0 || spike_total !== etot) begin
                n_bad++;
                $display("FAIL fire_period[%0d]: spike=%b state0=%0d total=%0d, want %b 0 %0d", k, spike, state[7:0], spike_total, esp, etot);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        current   = {24'd0, 8'd200};
        threshold = 8'd255;
        ena       = 1'b1;
        tick();
        n_total++;
        if (state[7:0] !== 8'd200 || spike !== 4'd0) begin
            n_bad++;
            $display("FAIL sat_edge1: state0=%0d spike=%b, want 200 0000", state[7:0], spike);
        end
        tick();
        n_total++;
        if (state[7:0] !== 8'd0 || spike !== 4'b0001 || spike_total !== 16'd1) begin
            n_bad++;
            $display("FAIL sat_edge2: state0=%0d spike=%b total=%0d, want 0 0001 1", state[7:0], spike, spike_total);
        end
    endtask

    task automatic test_all_clr();
        logic [3:0]  esp;
        logic [15:0] etot;
        do_reset();
        current   = {4{8'd200}};
        threshold = 8'd150;
        ena       = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cnt_clr = (k == 4);
            tick();
            cnt_clr = 1'b0;
            esp  = (k % 3 == 1) ? 4'b1111 : 4'b0000;
            etot = (k >= 4 && k <= 6) ? 16'd0 : 16'd4;
            n_total++;
            if (spike !== esp || spike_total !== etot || state !== 32'd0) begin
                n_bad++;
                $display("FAIL all_clr[%0d]: spike=%b total=%0d state=%h, want %b %0d 0", k, spike, spike_total, state, esp, etot);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        current   = {8'd0, 8'd0, 8'd200, 8'd40};
        threshold = 8'd100;
        ena       = 1'b1;
        tick();
        n_total++;
        if (state[7:0] !== 8'd40 || spike !== 4'b0010 || spike_total !== 16'd1) begin
            n_bad++;
            $display("FAIL hold_pre1: state0=%0d spike=%b total=%0d, want 40 0010 1", state[7:0], spike, spike_total);
        end
        tick();
        n_total++;
        if (state[7:0] !== 8'd60 || spike !== 4'b0000) begin
            n_bad++;
            $display("FAIL hold_pre2: state0=%0d spike=%b, want 60 0000", state[7:0], spike);
        end
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (state[7:0] !== 8'd60 || state[15:8] !== 8'd0 || spike !== 4'd0 || spike_total !== 16'd1) begin
                n_bad++;
                $display("FAIL hold[%0d]: state=%h spike=%b total=%0d, want state0=60 spike=0 total=1", i, state, spike, spike_total);
            end
        end
        ena = 1'b1;
        tick();
        n_total++;
        if (state[7:0] !== 8'd70 || spike !== 4'd0 || spike_total !== 16'd1) begin
            n_bad++;
            $display("FAIL hold_resume: state0=%0d spike=%b total=%0d, want 70 0000 1", state[7:0], spike, spike_total);
        end
        tick();
        n_total++;
        if (state[7:0] !== 8'd75 || spike !== 4'b0010 || spike_total !== 16'd2) begin
            n_bad++;
            $display("FAIL hold_refire: state0=%0d spike=%b total=%0d, want 75 0010 2", state[7:0], spike, spike_total);
        end
    endtask

    task automatic test_reset_refract();
        do_reset();
        current   = {24'd0, 8'd200};
        threshold = 8'd150;
        ena       = 1'b1;
        tick();
        n_total++;
        if (spike !== 4'b0001 || spike_total !== 16'd1) begin
            n_bad++;
            $display("FAIL rr_fire: spike=%b total=%0d, want 0001 1", spike, spike_total);
        end
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (spike !== 4'd0 || state !== 32'd0 || spike_total !== 16'd0) begin
            n_bad++;
            $display("FAIL rr_async: spike=%b state=%h total=%0d, want 0 0 0", spike, state, spike_total);
        end
        #2;
        rst_n = 1'b1;
        tick();
        n_total++;
        if (spike !== 4'b0001 || state !== 32'd0 || spike_total !== 16'd1) begin
            n_bad++;
            $display("FAIL rr_release: spike=%b state=%h total=%0d, want 0001 0 1", spike, state, spike_total);
        end
    endtask

    task automatic test_thr0_clr();
        logic [3:0] esp;
        do_reset();
        threshold = 8'd0;
        ena       = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            esp = (k % 3 == 1) ? 4'b1111 : 4'b0000;
            n_total++;
            if (spike !== esp || spike_total !== 16'(((k + 2) / 3) * 4)) begin
                n_bad++;
                $display("FAIL thr0[%0d]: spike=%b total=%0d, want %b %0d", k, spike, spike_total, esp, ((k + 2) / 3) * 4);
            end
        end
        ena     = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_total++;
        if (spike_total !== 16'd0 || spike !== 4'd0) begin
            n_bad++;
            $display("FAIL clr_no_ena: total=%0d spike=%b, want 0 0000", spike_total, spike);
        end
    endtask

    task automatic test_total_sat();
        do_reset();
        threshold = 8'd0;
        ena       = 1'b1;
        repeat (16383) tick();
        n_total++;
        if (spike_total_r0 !== 16'hFFFC || spike_r0 !== 4'b1111) begin
            n_bad++;
            $display("FAIL tot_pre: total=%h spike=%b, want fffc 1111", spike_total_r0, spike_r0);
        end
        tick();
        n_total++;
        if (spike_total_r0 !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL tot_sat1: total=%h, want ffff", spike_total_r0);
        end
        tick();
        n_total++;
        if (spike_total_r0 !== 16'hFFFF || spike_r0 !== 4'b1111 || state_r0 !== 32'd0) begin
            n_bad++;
            $display("FAIL tot_sat2: total=%h spike=%b state=%h, want ffff 1111 0", spike_total_r0, spike_r0, state_r0);
        end
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        ena       = 1'b0;
        cnt_clr   = 1'b0;
        current   = '0;
        threshold = '0;
        tick();
        test_reset();
        test_integrate();
        test_fire_period();
        test_saturate();
        test_all_clr();
        test_hold();
        test_reset_refract();
        test_thr0_clr();
        test_total_sat();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
